// File: rtl/v5_pulse_gen.sv
// Synthetic detector-pulse source for the v5 shaping-filter chain.
// Converts an amplitude request into a preamp-like ADC stream: a stepped
// rise of 2^RISE_SHIFT clocks followed by an exponential decay with
// tau ~ 2^DECAY_SHIFT clocks, all riding on a constant BASELINE.
module v5_pulse_gen #(
    parameter int SIZE_ADC_DATA = 12,
    parameter int BASELINE      = 100,
    parameter int RISE_SHIFT    = 1,
    parameter int DECAY_SHIFT   = 4,
    parameter int MIN_GAP       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trig_valid,
    input  logic [SIZE_ADC_DATA-1:0] trig_amp,
    output logic                     trig_ready,
    output logic [SIZE_ADC_DATA-1:0] adc_data,
    output logic                     busy,
    output logic [15:0]              pulse_cnt,
    output logic                     overflow
);

    // Excursion carries two headroom bits above the ADC range so pile-up
    // can exceed full scale before the output clamp engages.
    localparam int E_W         = SIZE_ADC_DATA + 2;
    localparam int RISE_LEN    = 1 << RISE_SHIFT;
    localparam int GAP_W       = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam int RCNT_W      = (RISE_SHIFT > 0) ? RISE_SHIFT : 1;
    localparam int ADC_MAX_INT = (1 << SIZE_ADC_DATA) - 1;
    localparam logic [E_W:0] DECAY_LIM = (E_W + 1)'(1 << DECAY_SHIFT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RISE  = 2'd1,
        DECAY = 2'd2
    } state_t;

    state_t                   state_reg,     state_next;
    logic [E_W-1:0]           e_reg,         e_next;
    logic [GAP_W-1:0]         gap_cnt_reg,   gap_cnt_next;
    logic [SIZE_ADC_DATA-1:0] step_reg,      step_next;
    logic [SIZE_ADC_DATA-1:0] rem_reg,       rem_next;
    logic [RCNT_W-1:0]        rise_cnt_reg,  rise_cnt_next;
    logic [SIZE_ADC_DATA-1:0] adc_data_reg,  adc_data_next;
    logic [15:0]              pulse_cnt_reg, pulse_cnt_next;
    logic                     overflow_reg,  overflow_next;

    logic                     accept;
    logic                     decay_floor;
    logic [SIZE_ADC_DATA-1:0] step_val;
    logic [SIZE_ADC_DATA-1:0] rem_val;
    logic [E_W-1:0]           base_e;
    logic [31:0]              level;

    // Add an ADC-width value to the excursion, pinning at all-ones on carry.
    function automatic logic [E_W-1:0] sat_add(input logic [E_W-1:0]           a,
                                                input logic [SIZE_ADC_DATA-1:0] b);
        logic [E_W:0] s;
        s = {1'b0, a} + {3'b000, b};
        sat_add = s[E_W] ? {E_W{1'b1}} : s[E_W-1:0];
    endfunction

    assign trig_ready = !reset && (state_reg != RISE) && (gap_cnt_reg == '0);
    assign accept     = trig_valid && trig_ready;
    assign busy       = (state_reg != IDLE);
    assign adc_data   = adc_data_reg;
    assign pulse_cnt  = pulse_cnt_reg;
    assign overflow   = overflow_reg;

    // Next-state, excursion arithmetic and output clamp.
    always_comb begin
        state_next     = state_reg;
        e_next         = e_reg;
        gap_cnt_next   = gap_cnt_reg;
        step_next      = step_reg;
        rem_next       = rem_reg;
        rise_cnt_next  = rise_cnt_reg;
        pulse_cnt_next = pulse_cnt_reg;

        step_val    = trig_amp >> RISE_SHIFT;
        rem_val     = trig_amp - SIZE_ADC_DATA'(RISE_LEN - 1) * step_val;
        decay_floor = ({1'b0, e_reg} < DECAY_LIM);
        // A decay edge that would truncate to zero is superseded by an
        // accept; the new rise then starts from zero rather than the residue.
        base_e      = (state_reg == DECAY && decay_floor) ? '0 : e_reg;

        if (gap_cnt_reg != '0) begin
            gap_cnt_next = gap_cnt_reg - GAP_W'(1);
        end

        if (accept) begin
            pulse_cnt_next = pulse_cnt_reg + 16'd1;
            gap_cnt_next   = GAP_W'(MIN_GAP - 1);
            step_next      = step_val;
            rem_next       = rem_val;
            rise_cnt_next  = RCNT_W'(RISE_LEN - 1);
            if (RISE_SHIFT == 0) begin
                e_next = sat_add(base_e, trig_amp);
            end else begin
                e_next = sat_add(base_e, step_val);
            end
            if (state_reg == IDLE && trig_amp == '0) begin
                state_next = IDLE;
            end else if (RISE_SHIFT == 0) begin
                state_next = DECAY;
            end else begin
                state_next = RISE;
            end
        end else begin
            case (state_reg)
                RISE: begin
                    if (rise_cnt_reg <= RCNT_W'(1)) begin
                        e_next     = sat_add(e_reg, rem_reg);
                        state_next = DECAY;
                    end else begin
                        e_next        = sat_add(e_reg, step_reg);
                        rise_cnt_next = rise_cnt_reg - RCNT_W'(1);
                    end
                end
                DECAY: begin
                    if (decay_floor) begin
                        e_next     = '0;
                        state_next = IDLE;
                    end else begin
                        e_next = e_reg - (e_reg >> DECAY_SHIFT);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // Output follows the excursion held before this edge, one clock behind.
        level = 32'(BASELINE) + 32'(e_reg);
        if (level > 32'(ADC_MAX_INT)) begin
            adc_data_next = SIZE_ADC_DATA'(ADC_MAX_INT);
            overflow_next = 1'b1;
        end else begin
            adc_data_next = SIZE_ADC_DATA'(level);
            overflow_next = overflow_reg;
        end
    end

    // State register; reset aborts any pulse in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            e_reg         <= '0;
            gap_cnt_reg   <= '0;
            step_reg      <= '0;
            rem_reg       <= '0;
            rise_cnt_reg  <= '0;
            adc_data_reg  <= SIZE_ADC_DATA'(BASELINE);
            pulse_cnt_reg <= '0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            e_reg         <= e_next;
            gap_cnt_reg   <= gap_cnt_next;
            step_reg      <= step_next;
            rem_reg       <= rem_next;
            rise_cnt_reg  <= rise_cnt_next;
            adc_data_reg  <= adc_data_next;
            pulse_cnt_reg <= pulse_cnt_next;
            overflow_reg  <= overflow_next;
        end
    end

endmodule

// File: tb/tb_v5_pulse_gen.sv
// Directed bench for v5_pulse_gen: one default-parameter instance and one
// with an instantaneous rise for the saturation scenario.
module tb_v5_pulse_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trig_valid = 1'b0;
    logic [11:0] trig_amp = '0;
    logic        trig_ready;
    logic [11:0] adc_data;
    logic        busy;
    logic [15:0] pulse_cnt;
    logic        overflow;

    logic        trig_valid_s = 1'b0;
    logic [11:0] trig_amp_s = '0;
    logic        trig_ready_s;
    logic [11:0] adc_data_s;
    logic        busy_s;
    logic [15:0] pulse_cnt_s;
    logic        overflow_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    v5_pulse_gen #(.SIZE_ADC_DATA(12)) dut (
        .clk(clk), .reset(reset), .trig_valid(trig_valid), .trig_amp(trig_amp),
        .trig_ready(trig_ready), .adc_data(adc_data), .busy(busy),
        .pulse_cnt(pulse_cnt), .overflow(overflow)
    );

    v5_pulse_gen #(.SIZE_ADC_DATA(12), .RISE_SHIFT(0)) dut_sat (
        .clk(clk), .reset(reset), .trig_valid(trig_valid_s), .trig_amp(trig_amp_s),
        .trig_ready(trig_ready_s), .adc_data(adc_data_s), .busy(busy_s),
        .pulse_cnt(pulse_cnt_s), .overflow(overflow_s)
    );

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; trig_valid = 1'b0; trig_valid_s = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++; if (trig_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_held: got %0d want 0", trig_ready); end
        reset = 1'b0;
        #1;
        n_cmp++; if (adc_data !== 12'd100) begin n_err++; $display("FAIL rst_adc: got %0d want 100", adc_data); end
        n_cmp++; if (trig_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %0d want 1", trig_ready); end
        n_cmp++; if (pulse_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", pulse_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0d want 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %0d want 0", overflow); end
        n_cmp++; if (adc_data_s !== 12'd100) begin n_err++; $display("FAIL rst_adc_s: got %0d want 100", adc_data_s); end
        n_cmp++; if (overflow_s !== 1'b0) begin n_err++; $display("FAIL rst_ovf_s: got %0d want 0", overflow_s); end
        $display("txn reset: adc=%0d ready=%0d cnt=%0d", adc_data, trig_ready, pulse_cnt);
    endtask

    task automatic test_single_pulse();
        int em;
        int old;
        int bound;
        int exp4 [4] = '{600, 1100, 1038, 980};
        do_reset();
        trig_valid = 1'b1; trig_amp = 12'd1000;
        tick();
        trig_valid = 1'b0;
        $display("txn single: amp=1000 accepted cnt=%0d", pulse_cnt);
        n_cmp++; if (pulse_cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt: got %0d want 1", pulse_cnt); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %0d want 1", busy); end
        n_cmp++; if (trig_ready !== 1'b0) begin n_err++; $display("FAIL single_ready: got %0d want 0", trig_ready); end
        n_cmp++; if (adc_data !== 12'd100) begin n_err++; $display("FAIL single_lag: got %0d want 100", adc_data); end
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (adc_data !== 12'(exp4[k])) begin n_err++; $display("FAIL single_t%0d: got %0d want %0d", k + 1, adc_data, exp4[k]); end
        end
        // e after edge T+4 is 825 (1000 -> 938 -> 880 -> 825).
        em = 825;
        bound = 0;
        while (em != 0 && bound < 200) begin
            tick();
            old = em;
            em = (em < 16) ? 0 : em - (em >> 4);
            bound++;
            n_cmp++; if (adc_data !== 12'(100 + old)) begin n_err++; $display("FAIL single_decay: got %0d want %0d", adc_data, 100 + old); end
            n_cmp++; if (busy !== (em != 0)) begin n_err++; $display("FAIL single_decay_busy: got %0d want %0d", busy, em != 0); end
        end
        if (em != 0) begin n_cmp++; n_err++; $display("FAIL single_timeout: got e=%0d want 0", em); end
        tick();
        n_cmp++; if (adc_data !== 12'd100) begin n_err++; $display("FAIL single_base: got %0d want 100", adc_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got %0d want 0", busy); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL single_ovf: got %0d want 0", overflow); end
        n_cmp++; if (pulse_cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt_end: got %0d want 1", pulse_cnt); end
    endtask

    task automatic test_odd_amp();
        int bound;
        do_reset();
        trig_valid = 1'b1; trig_amp = 12'd1001;
        tick();
        trig_valid = 1'b0;
        tick();
        n_cmp++; if (adc_data !== 12'd600) begin n_err++; $display("FAIL odd_step: got %0d want 600", adc_data); end
        tick();
        n_cmp++; if (adc_data !== 12'd1101) begin n_err++; $display("FAIL odd_peak: got %0d want 1101", adc_data); end
        tick();
        // 1001 - (1001 >> 4) = 939
        n_cmp++; if (adc_data !== 12'd1039) begin n_err++; $display("FAIL odd_decay: got %0d want 1039", adc_data); end
        $display("txn odd: amp=1001 peak seen cnt=%0d", pulse_cnt);
        bound = 0;
        while (busy && bound < 200) begin tick(); bound++; end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL odd_timeout: got busy=%0d want 0", busy); end
        n_cmp++; if (pulse_cnt !== 16'd1) begin n_err++; $display("FAIL odd_cnt: got %0d want 1", pulse_cnt); end
    endtask

    task automatic test_zero_amp();
        do_reset();
        trig_valid = 1'b1; trig_amp = 12'd0;
        tick();
        trig_valid = 1'b0;
        $display("txn zero: amp=0 cnt=%0d busy=%0d", pulse_cnt, busy);
        n_cmp++; if (pulse_cnt !== 16'd1) begin n_err++; $display("FAIL zero_cnt: got %0d want 1", pulse_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %0d want 0", busy); end
        n_cmp++; if (trig_ready !== 1'b0) begin n_err++; $display("FAIL zero_gap: got %0d want 0", trig_ready); end
        tick();
        n_cmp++; if (adc_data !== 12'd100) begin n_err++; $display("FAIL zero_adc: got %0d want 100", adc_data); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        trig_valid = 1'b1; trig_amp = 12'd1000;
        tick();                                  // edge T
        trig_valid = 1'b0;
        tick();                                  // T+1
        tick();                                  // T+2
        trig_valid = 1'b1; trig_amp = 12'd200;   // held from edge T+3
        for (int k = 3; k <= 14; k++) begin
            tick();
            n_cmp++; if (trig_ready !== 1'b0) begin n_err++; $display("FAIL b2b_holdoff_t%0d: got %0d want 0", k, trig_ready); end
            n_cmp++; if (pulse_cnt !== 16'd1) begin n_err++; $display("FAIL b2b_cnt_t%0d: got %0d want 1", k, pulse_cnt); end
        end
        tick();                                  // T+15
        n_cmp++; if (trig_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %0d want 1", trig_ready); end
        n_cmp++; if (adc_data !== 12'd536) begin n_err++; $display("FAIL b2b_t15: got %0d want 536", adc_data); end
        tick();                                  // T+16 accept
        trig_valid = 1'b0;
        $display("txn b2b: amp=200 accepted at T+16 cnt=%0d", pulse_cnt);
        n_cmp++; if (pulse_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_cnt: got %0d want 2", pulse_cnt); end
        n_cmp++; if (adc_data !== 12'd509) begin n_err++; $display("FAIL b2b_t16: got %0d want 509", adc_data); end
        tick();
        n_cmp++; if (adc_data !== 12'd609) begin n_err++; $display("FAIL b2b_t17: got %0d want 609", adc_data); end
        tick();
        n_cmp++; if (adc_data !== 12'd709) begin n_err++; $display("FAIL b2b_t18: got %0d want 709", adc_data); end
        tick();
        n_cmp++; if (adc_data !== 12'd671) begin n_err++; $display("FAIL b2b_t19: got %0d want 671", adc_data); end
        n_cmp++; if (pulse_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_cnt_end: got %0d want 2", pulse_cnt); end
    endtask

    task automatic test_saturation();
        int bound;
        do_reset();
        trig_valid_s = 1'b1; trig_amp_s = 12'd4095;
        tick();                                  // T
        trig_valid_s = 1'b0;
        n_cmp++; if (overflow_s !== 1'b0) begin n_err++; $display("FAIL sat_ovf_t0: got %0d want 0", overflow_s); end
        tick();                                  // T+1
        n_cmp++; if (adc_data_s !== 12'd4095) begin n_err++; $display("FAIL sat_adc_t1: got %0d want 4095", adc_data_s); end
        n_cmp++; if (overflow_s !== 1'b1) begin n_err++; $display("FAIL sat_ovf_t1: got %0d want 1", overflow_s); end
        tick();                                  // T+2: 100 + 3840
        n_cmp++; if (adc_data_s !== 12'd3940) begin n_err++; $display("FAIL sat_adc_t2: got %0d want 3940", adc_data_s); end
        $display("txn sat: amp=4095 cnt=%0d ovf=%0d", pulse_cnt_s, overflow_s);
        bound = 0;
        while (busy_s && bound < 400) begin tick(); bound++; end
        n_cmp++; if (busy_s !== 1'b0) begin n_err++; $display("FAIL sat_timeout: got busy=%0d want 0", busy_s); end
        tick();
        n_cmp++; if (adc_data_s !== 12'd100) begin n_err++; $display("FAIL sat_base: got %0d want 100", adc_data_s); end
        n_cmp++; if (overflow_s !== 1'b1) begin n_err++; $display("FAIL sat_sticky: got %0d want 1", overflow_s); end
        n_cmp++; if (pulse_cnt_s !== 16'd1) begin n_err++; $display("FAIL sat_cnt: got %0d want 1", pulse_cnt_s); end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        trig_valid = 1'b1; trig_amp = 12'd1000;
        tick();                                  // T
        trig_valid = 1'b0;
        repeat (11) tick();                      // T+11, e = 528
        n_cmp++; if (adc_data !== 12'd663) begin n_err++; $display("FAIL mid_pre: got %0d want 663", adc_data); end
        reset = 1'b1; trig_valid = 1'b1; trig_amp = 12'd300;
        tick();
        n_cmp++; if (adc_data !== 12'd100) begin n_err++; $display("FAIL mid_adc: got %0d want 100", adc_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %0d want 0", busy); end
        n_cmp++; if (pulse_cnt !== 16'd0) begin n_err++; $display("FAIL mid_cnt: got %0d want 0", pulse_cnt); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_ovf: got %0d want 0", overflow); end
        n_cmp++; if (trig_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready_rst: got %0d want 0", trig_ready); end
        reset = 1'b0;
        #1;
        n_cmp++; if (trig_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %0d want 1", trig_ready); end
        tick();
        trig_valid = 1'b0;
        $display("txn mid_reset: held amp=300 accepted cnt=%0d", pulse_cnt);
        n_cmp++; if (pulse_cnt !== 16'd1) begin n_err++; $display("FAIL mid_accept: got %0d want 1", pulse_cnt); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy2: got %0d want 1", busy); end
        tick();
        n_cmp++; if (adc_data !== 12'd250) begin n_err++; $display("FAIL mid_step: got %0d want 250", adc_data); end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_odd_amp();
        test_zero_amp();
        test_back_to_back();
        test_saturation();
        test_reset_mid_pulse();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
